// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage feeding the IF/ID register.
// Owns the PC and keeps at most one read outstanding on a variable-latency
// request/response instruction-memory port. When no fetched instruction is
// held, a bubble is presented instead.
module fetch_unit #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter logic [31:0] BUBBLE_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        StallF,
  input  logic        RedirectE,
  input  logic [31:0] PCTargetE,
  output logic        ImemReq,
  output logic [31:0] ImemAddr,
  input  logic        ImemRvalid,
  input  logic [31:0] ImemRdata,
  output logic [31:0] InstrF,
  output logic [31:0] PCF,
  output logic [31:0] PCPlus4F,
  output logic        FetchValidF
);

  // ISSUE: request on the bus; WAIT: response pending;
  // READY: instruction held for IF/ID; DISCARD: response pending but stale.
  typedef enum logic [1:0] {
    ISSUE   = 2'd0,
    WAIT    = 2'd1,
    READY   = 2'd2,
    DISCARD = 2'd3
  } state_t;

  state_t      state_reg;
  logic [31:0] pc_reg;
  logic [31:0] instr_buf_reg;
  logic        valid_reg;
  logic [31:0] redirect_pc;
  logic        unused_target_bits;

  // Redirect targets are always word aligned; the low bits are dropped.
  assign redirect_pc        = {PCTargetE[31:2], 2'b00};
  assign unused_target_bits = ^PCTargetE[1:0];

  // Fetch sequencer: PC, state, instruction buffer and valid flag.
  // RedirectE is tested first everywhere so it always beats StallF.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= ISSUE;
      pc_reg        <= RESET_PC;
      instr_buf_reg <= '0;
      valid_reg     <= 1'b0;
    end else begin
      case (state_reg)
        ISSUE: begin
          // The request is accepted this cycle, so a redirect must still
          // swallow its response later. Any rvalid seen here is ignored.
          if (RedirectE) begin
            pc_reg    <= redirect_pc;
            state_reg <= DISCARD;
          end else begin
            state_reg <= WAIT;
          end
        end
        WAIT: begin
          if (ImemRvalid && RedirectE) begin
            // Response arrived for the wrong path: drop it and refetch now.
            pc_reg    <= redirect_pc;
            state_reg <= ISSUE;
          end else if (ImemRvalid) begin
            instr_buf_reg <= ImemRdata;
            valid_reg     <= 1'b1;
            state_reg     <= READY;
          end else if (RedirectE) begin
            pc_reg    <= redirect_pc;
            state_reg <= DISCARD;
          end
        end
        DISCARD: begin
          // Latest redirect target wins while the stale response drains.
          if (RedirectE) begin
            pc_reg <= redirect_pc;
          end
          if (ImemRvalid) begin
            state_reg <= ISSUE;
          end
        end
        READY: begin
          if (RedirectE) begin
            pc_reg    <= redirect_pc;
            valid_reg <= 1'b0;
            state_reg <= ISSUE;
          end else if (!StallF) begin
            pc_reg    <= pc_reg + 32'd4;
            valid_reg <= 1'b0;
            state_reg <= ISSUE;
          end
        end
        default: begin
          state_reg <= ISSUE;
          valid_reg <= 1'b0;
        end
      endcase
    end
  end

  // Output decode; the request is masked while reset is held.
  always_comb begin
    ImemReq     = (state_reg == ISSUE) && !reset;
    ImemAddr    = pc_reg;
    PCF         = pc_reg;
    PCPlus4F    = pc_reg + 32'd4;
    FetchValidF = valid_reg;
    InstrF      = valid_reg ? instr_buf_reg : BUBBLE_INSTR;
  end

endmodule
